// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for the two-master Wishbone arbiter.
// Carries both master ports (m0 = data, m1 = instruction) and the single
// slave port.
//   slave  modport : the arbiter's view (takes master requests and slave
//                    responses, drives slave requests and master responses)
//   master modport : the surrounding system's view (drives the masters'
//                    requests and the slave's responses)
interface wb_arbiter_2m_if;
  // master 0 (data port)
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  // master 1 (instruction port)
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  // shared slave
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with a per-grant bus timeout.
// A master owns the slave from the cycle after it is granted until it drops
// cyc (locked grant across any number of strobes). Ties in IDLE go to the
// master that was not granted last. If the granted master strobes for
// TIMEOUT cycles without an ack, it gets a one-cycle err and loses the grant.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - wb_arbiter_2m_if.slave: both master ports plus the slave port
// Parameter:
//   TIMEOUT - unacked strobe cycles tolerated before err (1..255)
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  wb_arbiter_2m_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] cnt_q, cnt_d;

  // Requests of whichever master currently owns the bus.
  logic cur_cyc, cur_stb, granted, timeout;

  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign cur_cyc = (state_q == GNT1) ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign cur_stb = (state_q == GNT1) ? bus.m1_stb_i : bus.m0_stb_i;
  // An ack in the same cycle beats the timeout.
  assign timeout = granted && (cnt_q == TIMEOUT_C) && !bus.s_ack_i;

  // State register
  // NOTE: state uses non-blocking assignments so every register updates
  // from the same pre-edge values; the reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic
  // NOTE: every output of this block gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // m0 wins when alone, or on a tie when m1 was granted last.
        if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!cur_cyc || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.s_ack_i || !cur_stb) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: pure routing from the current grant.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_sel_o  = '0;
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_dat_o = '0;
    unique case (state_q)
      GNT0: begin
        bus.s_cyc_o  = bus.m0_cyc_i && !timeout;
        bus.s_stb_o  = bus.m0_stb_i && !timeout;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_ack_o = bus.s_ack_i && !rst;
        bus.m0_err_o = timeout && !rst;
        bus.m0_dat_o = rst ? 32'h0 : bus.s_dat_i;
      end
      GNT1: begin
        bus.s_cyc_o  = bus.m1_cyc_i && !timeout;
        bus.s_stb_o  = bus.m1_stb_i && !timeout;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_ack_o = bus.s_ack_i && !rst;
        bus.m1_err_o = timeout && !rst;
        bus.m1_dat_o = rst ? 32'h0 : bus.s_dat_i;
      end
      default: ;  // IDLE: everything stays 0, stray slave acks are dropped
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  wb_arbiter_2m_if bus ();

  wb_arbiter_2m #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_sel_i = 4'h0;
    bus.m0_adr_i = 0; bus.m0_dat_i = 0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_sel_i = 4'h0;
    bus.m1_adr_i = 0; bus.m1_dat_i = 0;
    bus.s_ack_i  = 0; bus.s_dat_i  = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.s_ack_i = 1; bus.s_dat_i = 32'hA5A5A5A5;
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    tick();
    checks++; if (bus.m0_ack_o !== 1'b0 || bus.m0_err_o !== 1'b0 || bus.m0_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_m0_outs: ack=%b err=%b dat=%h want 0/0/0", bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o); end
    checks++; if (bus.m1_ack_o !== 1'b0 || bus.m1_err_o !== 1'b0 || bus.m1_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_m1_outs: ack=%b err=%b dat=%h want 0/0/0", bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o); end
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin
      errors++; $display("FAIL reset_slave_outs: cyc=%b stb=%b adr=%h want 0/0/0", bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o); end
    tick();
    rst = 0;
    idle_inputs();
    bus.s_ack_i = 1;
    #1;
    checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_ack: m0=%b m1=%b want 0/0", bus.m0_ack_o, bus.m1_ack_o); end
    bus.s_ack_i = 0;
    tick();
  endtask

  // Tie after reset goes to m0; m1 follows after one IDLE cycle; read routing.
  task automatic test_tie_and_read();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h100; bus.m0_sel_i = 4'hF;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h200; bus.m1_sel_i = 4'h3;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL tie_latency: s_cyc=%b want 0", bus.s_cyc_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h100 || bus.s_sel_o !== 4'hF) begin
      errors++; $display("FAIL tie_gnt0: cyc=%b adr=%h sel=%h want 1/100/f", bus.s_cyc_o, bus.s_adr_o, bus.s_sel_o); end
    tick();
    bus.s_ack_i = 1; bus.s_dat_i = 32'h12345678;
    #1;
    checks++; if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 32'h12345678) begin
      errors++; $display("FAIL tie_m0_ack: ack=%b dat=%h want 1/12345678", bus.m0_ack_o, bus.m0_dat_o); end
    checks++; if (bus.m1_ack_o !== 1'b0 || bus.m1_dat_o !== 32'h0) begin
      errors++; $display("FAIL tie_m1_quiet: ack=%b dat=%h want 0/0", bus.m1_ack_o, bus.m1_dat_o); end
    tick();
    bus.s_ack_i = 0; bus.s_dat_i = 0;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    tick();
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin
      errors++; $display("FAIL tie_idle_gap: cyc=%b adr=%h want 0/0", bus.s_cyc_o, bus.s_adr_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h200) begin
      errors++; $display("FAIL tie_gnt1: cyc=%b adr=%h want 1/200", bus.s_cyc_o, bus.s_adr_o); end
    bus.s_ack_i = 1; bus.s_dat_i = 32'hDEADBEEF;
    #1;
    checks++; if (bus.m1_ack_o !== 1'b1 || bus.m1_dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_m1: ack=%b dat=%h want 1/deadbeef", bus.m1_ack_o, bus.m1_dat_o); end
    checks++; if (bus.m0_ack_o !== 1'b0 || bus.m0_dat_o !== 32'h0) begin
      errors++; $display("FAIL read_m0_quiet: ack=%b dat=%h want 0/0", bus.m0_ack_o, bus.m0_dat_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  // Round robin both ways, plus a locked multi-strobe grant.
  task automatic test_round_robin_lock();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h1000;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h2000;
    tick();
    checks++; if (bus.s_adr_o !== 32'h1000) begin
      errors++; $display("FAIL rr_after_m1: adr=%h want 1000", bus.s_adr_o); end
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    tick();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rr_idle_gap: s_cyc=%b want 0", bus.s_cyc_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h2000) begin
      errors++; $display("FAIL rr_after_m0: cyc=%b adr=%h want 1/2000", bus.s_cyc_o, bus.s_adr_o); end
    bus.s_ack_i = 1;
    #1;
    checks++; if (bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL lock_ack1: m1=%b m0=%b want 1/0", bus.m1_ack_o, bus.m0_ack_o); end
    tick();
    bus.m1_adr_i = 32'h2004;
    #1;
    checks++; if (bus.s_adr_o !== 32'h2004 || bus.m1_ack_o !== 1'b1) begin
      errors++; $display("FAIL lock_ack2: adr=%h ack=%b want 2004/1", bus.s_adr_o, bus.m1_ack_o); end
    tick();
    bus.s_ack_i = 0;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h2004) begin
      errors++; $display("FAIL lock_hold: cyc=%b adr=%h want 1/2004", bus.s_cyc_o, bus.s_adr_o); end
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    tick();
    checks++; if (bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL lock_release_idle: s_cyc=%b want 0", bus.s_cyc_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h1000) begin
      errors++; $display("FAIL lock_waiter_gnt: cyc=%b adr=%h want 1/1000", bus.s_cyc_o, bus.s_adr_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_ack();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hCAFE0000;
    #1;
    checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0 || bus.m0_dat_o !== 32'h0) begin
      errors++; $display("FAIL idle_ack: m0=%b m1=%b dat=%h want 0/0/0", bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o); end
    tick();
    idle_inputs();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h44;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL idle_ack_state: s_cyc=%b want 0", bus.s_cyc_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  // TIMEOUT=4: err on the 5th granted cycle, then re-arbitration, then ack-wins.
  task automatic test_timeout();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h500;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.m0_err_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin
        errors++; $display("FAIL to_wait_%0d: err=%b stb=%b want 0/1", i, bus.m0_err_o, bus.s_stb_o); end
      tick();
    end
    checks++; if (bus.m0_err_o !== 1'b1 || bus.s_stb_o !== 1'b0 || bus.s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL to_err: err=%b stb=%b cyc=%b want 1/0/0", bus.m0_err_o, bus.s_stb_o, bus.s_cyc_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.m0_err_o !== 1'b0) begin
      errors++; $display("FAIL to_idle: cyc=%b err=%b want 0/0", bus.s_cyc_o, bus.m0_err_o); end
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h500) begin
      errors++; $display("FAIL to_regrant: cyc=%b adr=%h want 1/500", bus.s_cyc_o, bus.s_adr_o); end
    for (int i = 0; i < 4; i++) tick();
    bus.s_ack_i = 1;
    #1;
    checks++; if (bus.m0_ack_o !== 1'b1 || bus.m0_err_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin
      errors++; $display("FAIL to_ack_wins: ack=%b err=%b stb=%b want 1/0/1", bus.m0_ack_o, bus.m0_err_o, bus.s_stb_o); end
    tick();
    bus.s_ack_i = 0;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.m0_err_o !== 1'b0) begin
      errors++; $display("FAIL to_kept_grant: cyc=%b err=%b want 1/0", bus.s_cyc_o, bus.m0_err_o); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.m0_err_o !== 1'b1) begin
      errors++; $display("FAIL to_counter_cleared: err=%b want 1", bus.m0_err_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h300;
    tick();
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h300) begin
      errors++; $display("FAIL rmt_gnt1: cyc=%b adr=%h want 1/300", bus.s_cyc_o, bus.s_adr_o); end
    rst = 1; bus.s_ack_i = 1; bus.s_dat_i = 32'h0BADF00D;
    #1;
    checks++; if (bus.m1_ack_o !== 1'b0 || bus.m1_err_o !== 1'b0 || bus.m1_dat_o !== 32'h0) begin
      errors++; $display("FAIL rmt_aborted: ack=%b err=%b dat=%h want 0/0/0", bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o); end
    tick();
    rst = 0;
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 32'h600;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL rmt_after: cyc=%b m1_ack=%b want 0/0", bus.s_cyc_o, bus.m1_ack_o); end
    bus.s_ack_i = 0; bus.s_dat_i = 0;
    tick();
    checks++; if (bus.s_adr_o !== 32'h600) begin
      errors++; $display("FAIL rmt_tie_m0: adr=%h want 600", bus.s_adr_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_tie_and_read();
    test_round_robin_lock();
    test_idle_ack();
    test_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of granted cycles with stb high and no ack before a bus error is raised (range 1..255).
REQ-002 The block SHALL have the following ports.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (data port) Wishbone control.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_dat_o  out  32  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and bus error.
- m1_*  (same set, same directions and widths)  master 1 (instruction port).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave Wishbone control.
- s_sel_o  out  4  slave byte select.
- s_adr_o, s_dat_o  out  32 each  slave address and write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.

Function
REQ-003 The FSM SHALL have three states: IDLE, GNT0 and GNT1. A 1-bit register last_gnt SHALL record the most recent grant. A timeout counter SHALL be 8 bits wide.
REQ-004 Arbitration in IDLE:
- Only m0_cyc_i high: next state is GNT0.
- Only m1_cyc_i high: next state is GNT1.
- Both high: grant the master not equal to last_gnt (round robin).
- Neither high: stay in IDLE.
REQ-005 A grant SHALL take effect on the cycle after the request is sampled; arbitration latency is exactly 1 cycle.
REQ-006 On entry to GNTn, last_gnt SHALL be set to n and the timeout counter SHALL be cleared.
REQ-007 In GNTn, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL be combinational copies of master n's inputs.
REQ-008 In IDLE, all slave outputs SHALL be driven to 0.
REQ-009 In GNTn:
- mn_ack_o = s_ack_i and mn_dat_o = s_dat_i, combinationally.
- The non-granted master SHALL see ack=0, err=0 and dat=0.
REQ-010 GNTn SHALL return to IDLE on the first cycle mn_cyc_i is sampled low. There SHALL be no direct GNT0-to-GNT1 transition, so at least one IDLE cycle separates grants.
REQ-011 Timeout counter in GNTn:
- Increment each cycle with mn_stb_i=1 and s_ack_i=0.
- Clear on s_ack_i=1 or mn_stb_i=0.
REQ-012 When the counter equals TIMEOUT and s_ack_i=0:
- Assert mn_err_o for exactly that one cycle.
- Force s_cyc_o and s_stb_o low in that cycle.
- Go to IDLE next cycle.
REQ-013 If s_ack_i and the timeout condition coincide, the ack SHALL win: ack is passed, err stays 0, and the counter clears.
REQ-014 A master that keeps cyc high after err SHALL be re-arbitrated normally from IDLE under the same round-robin rule.
REQ-015 An ack arriving while in IDLE SHALL be ignored: no master ack and no state change.
REQ-016 The block SHALL treat a master that holds cyc high across several ack'd strobes as one locked grant. The other master waits until cyc drops.

Reset
REQ-017 While rst=1 at a clock edge, the next state SHALL be:
- state = IDLE
- last_gnt = 1, so m0 wins the first tie
- timeout counter = 0
REQ-018 Reset SHALL abort any grant in progress. No ack or err SHALL be emitted for the aborted cycle, and all slave outputs SHALL be 0 from the next cycle.
REQ-019 During and immediately after reset, all mX_ack_o, mX_err_o and mX_dat_o SHALL be 0.

Verification
REQ-020 Tie after reset: m0 and m1 raise cyc/stb in the same cycle, and the slave acks after 2 cycles.
- GNT0 one cycle later.
- s_adr_o = m0_adr_i.
- m0_ack_o pulses; m1 sees no ack.
- After m0 drops cyc: IDLE for 1 cycle, then GNT1.
REQ-021 Round robin: m1 granted last, then both request again -> m0 is granted. Repeat with m0 last -> m1 is granted.
REQ-022 Read data routing: m1 read, s_dat_i=32'hDEADBEEF with ack -> m1_dat_o=32'hDEADBEEF in the ack cycle, and m0_dat_o=0.
REQ-023 Timeout: TIMEOUT=4, slave never acks.
- m0_err_o=1 on the 5th granted cycle (counter = 4).
- s_stb_o=0 in that cycle.
- State is IDLE the next cycle.
- Re-run with the ack arriving in the same cycle the counter reaches TIMEOUT -> ack passed, no err.
REQ-024 Reset mid-transfer: rst=1 while in GNT1 with stb high -> s_cyc_o=0 next cycle, no m1 ack/err, and the next tie goes to m0.
